cannon_ctrl: RTL

//  Per-frame sequencer for the player laser cannon. Converts the USB keycode into

---
 rtl/cannon_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cannon_ctrl.sv
// cannon_ctrl: per-frame player cannon sequencer.
// Turns keycodes into cannon motion and missile launches on each frame_tick.
// Also runs the life cycle ALIVE -> EXPLODE -> RESPAWN/GAME_OVER.
module cannon_ctrl #(
    parameter int          X_MIN          = 8,
    parameter int          X_MAX          = 631,
    parameter int          X_START        = 320,
    parameter int          X_STEP         = 2,
    parameter logic [7:0]  KEY_RIGHT      = 8'h4F,
    parameter logic [7:0]  KEY_LEFT       = 8'h50,
    parameter logic [7:0]  KEY_FIRE       = 8'h2C,
    parameter int          COOLDOWN       = 16,
    parameter int          EXPLODE_FRAMES = 60,
    parameter int          LIVES_INIT     = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       missile_busy,
    input  logic       cannon_hit,
    output logic [9:0] cannon_x,
    output logic       fire_launch,
    output logic [9:0] fire_x,
    output logic [1:0] lives,
    output logic       exploding,
    output logic       game_over
);

    typedef enum logic [1:0] {ALIVE, EXPLODE, RESPAWN, GAME_OVER} state_t;

    // The cooldown counter is 4 bits wide, so a request of 16 or more frames clamps to 15.
    localparam logic [3:0] CD_LOAD  = 4'((COOLDOWN > 15) ? 15 : COOLDOWN);
    localparam logic [5:0] EXP_LOAD = 6'(EXPLODE_FRAMES - 1);
    localparam logic [9:0] XS       = 10'(X_START);

    state_t     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] fire_x_q, fire_x_d;
    logic       fire_q, fire_d;
    logic [1:0] lives_q, lives_d;
    logic [3:0] cd_q, cd_d;
    logic [5:0] cnt_q, cnt_d;
    logic       hit_pend_q, hit_pend_d;
    logic [10:0] x_sum;

    // State register: every flop returns to its reset value asynchronously.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ALIVE;
            x_q        <= XS;
            fire_x_q   <= '0;
            fire_q     <= 1'b0;
            lives_q    <= 2'(LIVES_INIT);
            cd_q       <= '0;
            cnt_q      <= '0;
            hit_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            fire_x_q   <= fire_x_d;
            fire_q     <= fire_d;
            lives_q    <= lives_d;
            cd_q       <= cd_d;
            cnt_q      <= cnt_d;
            hit_pend_q <= hit_pend_d;
        end
    end

    // Next-state logic: positions and state change only on frame ticks; a launch lasts one cycle.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        fire_x_d   = fire_x_q;
        fire_d     = 1'b0;
        lives_d    = lives_q;
        cd_d       = cd_q;
        cnt_d      = cnt_q;
        hit_pend_d = hit_pend_q;
        // Use an 11-bit sum so a step past X_MAX is detected before it can wrap.
        x_sum      = {1'b0, x_q} + 11'(X_STEP);

        if (frame_tick && cd_q != 4'd0)
            cd_d = cd_q - 4'd1;

        case (state_q)
            ALIVE: begin
                if (cannon_hit)
                    hit_pend_d = 1'b1;
                if (frame_tick) begin
                    if (hit_pend_q || cannon_hit) begin
                        state_d    = EXPLODE;
                        lives_d    = lives_q - 2'd1;
                        cnt_d      = EXP_LOAD;
                        hit_pend_d = 1'b0;
                    end else if (keycode == KEY_RIGHT) begin
                        x_d = (x_sum > 11'(X_MAX)) ? 10'(X_MAX) : x_sum[9:0];
                    end else if (keycode == KEY_LEFT) begin
                        x_d = (x_q < 10'(X_MIN + X_STEP)) ? 10'(X_MIN) : x_q - 10'(X_STEP);
                    end else if (keycode == KEY_FIRE && !missile_busy && cd_q == 4'd0) begin
                        fire_d   = 1'b1;
                        fire_x_d = x_q;
                        cd_d     = CD_LOAD;
                    end
                end
            end
            EXPLODE: begin
                if (frame_tick) begin
                    if (cnt_q == 6'd0) begin
                        if (lives_q == 2'd0) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d = RESPAWN;
                            x_d     = XS;
                        end
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            RESPAWN: begin
                // Wait for the key to be released so a held fire key cannot shoot on spawn.
                x_d        = XS;
                hit_pend_d = 1'b0;
                if (frame_tick && keycode == 8'h00)
                    state_d = ALIVE;
            end
            default: ; // GAME_OVER: frozen until reset
        endcase
    end

    assign cannon_x    = x_q;
    assign fire_launch = fire_q;
    assign fire_x      = fire_x_q;
    assign lives       = lives_q;
    assign exploding   = (state_q == EXPLODE);
    assign game_over   = (state_q == GAME_OVER);

endmodule
